// File: rtl/reservation_station_if.sv
// Dispatch, wakeup and issue signal bundle of the reservation station.
// master: Rename/FU side. slave: the reservation station itself.
interface reservation_station_if #(
  parameter int PAYLOAD_W = 32
);
  logic                 dispatch_valid;
  logic                 dispatch_ready;
  logic [5:0]           dispatch_rd;
  logic [5:0]           dispatch_rs1;
  logic [5:0]           dispatch_rs2;
  logic                 dispatch_rs1_ready;
  logic                 dispatch_rs2_ready;
  logic [31:0]          dispatch_rs1_value;
  logic [31:0]          dispatch_rs2_value;
  logic [PAYLOAD_W-1:0] dispatch_payload;

  logic                 wakeup_active;
  logic [5:0]           wakeup_tag;
  logic [31:0]          wakeup_value;

  logic                 issue_valid;
  logic                 issue_ready;
  logic [5:0]           issue_rd;
  logic [31:0]          issue_rs1_value;
  logic [31:0]          issue_rs2_value;
  logic [PAYLOAD_W-1:0] issue_payload;

  modport master (
    output dispatch_valid,
    input  dispatch_ready,
    output dispatch_rd,
    output dispatch_rs1,
    output dispatch_rs2,
    output dispatch_rs1_ready,
    output dispatch_rs2_ready,
    output dispatch_rs1_value,
    output dispatch_rs2_value,
    output dispatch_payload,
    output wakeup_active,
    output wakeup_tag,
    output wakeup_value,
    input  issue_valid,
    output issue_ready,
    input  issue_rd,
    input  issue_rs1_value,
    input  issue_rs2_value,
    input  issue_payload
  );

  modport slave (
    input  dispatch_valid,
    output dispatch_ready,
    input  dispatch_rd,
    input  dispatch_rs1,
    input  dispatch_rs2,
    input  dispatch_rs1_ready,
    input  dispatch_rs2_ready,
    input  dispatch_rs1_value,
    input  dispatch_rs2_value,
    input  dispatch_payload,
    input  wakeup_active,
    input  wakeup_tag,
    input  wakeup_value,
    output issue_valid,
    input  issue_ready,
    output issue_rd,
    output issue_rs1_value,
    output issue_rs2_value,
    output issue_payload
  );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: tag-matching wakeup, lowest-index issue select.
// Ports: clk, reset_n (async low), flush, rs (slave bundle), occupancy.
module reservation_station #(
  parameter int NUM_ENTRIES = 8,
  parameter int PAYLOAD_W   = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  reservation_station_if.slave rs,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] occupancy
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(NUM_ENTRIES+1);

  typedef struct packed {
    logic                 valid;
    logic [5:0]           rd;
    logic [5:0]           t1;
    logic [5:0]           t2;
    logic                 r1;
    logic                 r2;
    logic [31:0]          v1;
    logic [31:0]          v2;
    logic [PAYLOAD_W-1:0] pl;
  } ent_t;

  ent_t ent_q [NUM_ENTRIES];
  ent_t ent_d [NUM_ENTRIES];
  ent_t new_ent;

  logic [CNT_W-1:0] occ_q, occ_d;
  logic [IDX_W-1:0] iss_idx, free_idx;
  logic iss_hit;
  logic disp_fire, iss_fire, wk_en;
  logic m1, m2;

  assign wk_en = rs.wakeup_active
               && (rs.wakeup_tag != 6'd0);

  assign rs.dispatch_ready =
    (occ_q < CNT_W'(NUM_ENTRIES));
  assign disp_fire = rs.dispatch_valid
                   && rs.dispatch_ready;
  assign iss_fire = iss_hit && rs.issue_ready;
  assign occupancy = occ_q;

  // Descending scans leave the lowest matching index.
  always_comb begin
    iss_hit  = 1'b0;
    iss_idx  = '0;
    free_idx = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].r1
          && ent_q[i].r2) begin
        iss_hit = 1'b1;
        iss_idx = IDX_W'(i);
      end
      if (!ent_q[i].valid)
        free_idx = IDX_W'(i);
    end
  end

  assign rs.issue_valid = iss_hit;
  assign rs.issue_rd =
    iss_hit ? ent_q[iss_idx].rd : '0;
  assign rs.issue_rs1_value =
    iss_hit ? ent_q[iss_idx].v1 : '0;
  assign rs.issue_rs2_value =
    iss_hit ? ent_q[iss_idx].v2 : '0;
  assign rs.issue_payload =
    iss_hit ? ent_q[iss_idx].pl : '0;

  // An operand broadcast in the dispatch cycle is captured on entry.
  always_comb begin
    m1 = wk_en && (rs.dispatch_rs1 == rs.wakeup_tag);
    m2 = wk_en && (rs.dispatch_rs2 == rs.wakeup_tag);
    new_ent.valid = 1'b1;
    new_ent.rd = rs.dispatch_rd;
    new_ent.t1 = rs.dispatch_rs1;
    new_ent.t2 = rs.dispatch_rs2;
    new_ent.r1 = rs.dispatch_rs1_ready || m1;
    new_ent.r2 = rs.dispatch_rs2_ready || m2;
    new_ent.v1 = rs.dispatch_rs1_ready
               ? rs.dispatch_rs1_value
               : (m1 ? rs.wakeup_value : '0);
    new_ent.v2 = rs.dispatch_rs2_ready
               ? rs.dispatch_rs2_value
               : (m2 ? rs.wakeup_value : '0);
    new_ent.pl = rs.dispatch_payload;
  end

  // free_idx is always an invalid slot, so never the issuing one.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (wk_en && ent_q[i].valid) begin
        if (!ent_q[i].r1
            && ent_q[i].t1 == rs.wakeup_tag) begin
          ent_d[i].r1 = 1'b1;
          ent_d[i].v1 = rs.wakeup_value;
        end
        if (!ent_q[i].r2
            && ent_q[i].t2 == rs.wakeup_tag) begin
          ent_d[i].r2 = 1'b1;
          ent_d[i].v2 = rs.wakeup_value;
        end
      end
    end
    if (iss_fire)
      ent_d[iss_idx].valid = 1'b0;
    if (disp_fire)
      ent_d[free_idx] = new_ent;
    if (flush)
      for (int i = 0; i < NUM_ENTRIES; i++)
        ent_d[i].valid = 1'b0;
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({disp_fire, iss_fire})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
    if (flush)
      occ_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
        ent_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < NUM_ENTRIES; i++)
        ent_q[i] <= ent_d[i];
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station.
// Expected issues are queued at dispatch and popped on issue fire.
module tb_reservation_station;
  logic clk;
  logic reset_n;
  logic flush;
  logic [3:0] occupancy;

  reservation_station_if #(.PAYLOAD_W(32)) rs_if();

  reservation_station #(
    .NUM_ENTRIES(8),
    .PAYLOAD_W(32)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .rs(rs_if),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [5:0]  rd;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] pl;
  } exp_t;

  exp_t sb[$];
  int n_chk;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] rd,
                      input logic [31:0] v1,
                      input logic [31:0] v2,
                      input logic [31:0] pl);
    exp_t e;
    e.rd = rd; e.v1 = v1;
    e.v2 = v2; e.pl = pl;
    sb.push_back(e);
  endtask

  task automatic disp(input logic [5:0] rd,
                      input logic [5:0] t1,
                      input logic r1,
                      input logic [31:0] v1,
                      input logic [5:0] t2,
                      input logic r2,
                      input logic [31:0] v2,
                      input logic [31:0] pl);
    rs_if.dispatch_rd        = rd;
    rs_if.dispatch_rs1       = t1;
    rs_if.dispatch_rs1_ready = r1;
    rs_if.dispatch_rs1_value = v1;
    rs_if.dispatch_rs2       = t2;
    rs_if.dispatch_rs2_ready = r2;
    rs_if.dispatch_rs2_value = v2;
    rs_if.dispatch_payload   = pl;
    rs_if.dispatch_valid     = 1'b1;
    step();
    rs_if.dispatch_valid     = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n && !flush && rs_if.issue_valid
        && rs_if.issue_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("iss_rd", 64'(rs_if.issue_rd), 64'(e.rd));
        chk("iss_v1", 64'(rs_if.issue_rs1_value),
            64'(e.v1));
        chk("iss_v2", 64'(rs_if.issue_rs2_value),
            64'(e.v2));
        chk("iss_pl", 64'(rs_if.issue_payload),
            64'(e.pl));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_n = 1'b0;
    flush = 1'b0;
    rs_if.dispatch_valid = 1'b0;
    rs_if.dispatch_rd = '0;
    rs_if.dispatch_rs1 = '0;
    rs_if.dispatch_rs2 = '0;
    rs_if.dispatch_rs1_ready = 1'b0;
    rs_if.dispatch_rs2_ready = 1'b0;
    rs_if.dispatch_rs1_value = '0;
    rs_if.dispatch_rs2_value = '0;
    rs_if.dispatch_payload = '0;
    rs_if.wakeup_active = 1'b0;
    rs_if.wakeup_tag = '0;
    rs_if.wakeup_value = '0;
    rs_if.issue_ready = 1'b0;
    #2;
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ivalid", 64'(rs_if.issue_valid), 64'd0);
    chk("rst_irdy", 64'(rs_if.dispatch_ready), 64'd1);
    chk("rst_ird", 64'(rs_if.issue_rd), 64'd0);
    @(posedge clk);
    step();
    reset_n = 1'b1;

    // ready dispatch issues next cycle
    rs_if.issue_ready = 1'b1;
    push(6'd33, 32'd5, 32'd7, 32'h100);
    disp(6'd33, 6'd1, 1'b1, 32'd5,
         6'd2, 1'b1, 32'd7, 32'h100);
    chk("rdy_ivalid", 64'(rs_if.issue_valid), 64'd1);
    chk("rdy_rd", 64'(rs_if.issue_rd), 64'd33);
    step();
    chk("rdy_occ", 64'(occupancy), 64'd0);

    // wakeup after dispatch
    disp(6'd34, 6'd40, 1'b0, 32'd0,
         6'd3, 1'b1, 32'd9, 32'h200);
    chk("wk_wait", 64'(rs_if.issue_valid), 64'd0);
    chk("wk_occ", 64'(occupancy), 64'd1);
    rs_if.wakeup_active = 1'b1;
    rs_if.wakeup_tag = 6'd0;
    rs_if.wakeup_value = 32'hdead;
    step();
    chk("wk_p0", 64'(rs_if.issue_valid), 64'd0);
    chk("wk_p0_occ", 64'(occupancy), 64'd1);
    push(6'd34, 32'h1234, 32'd9, 32'h200);
    rs_if.wakeup_tag = 6'd40;
    rs_if.wakeup_value = 32'h1234;
    chk("wk_same_cyc", 64'(rs_if.issue_valid), 64'd0);
    step();
    rs_if.wakeup_active = 1'b0;
    chk("wk_ivalid", 64'(rs_if.issue_valid), 64'd1);
    chk("wk_v1", 64'(rs_if.issue_rs1_value),
        64'h1234);
    step();
    chk("wk_occ0", 64'(occupancy), 64'd0);

    // wakeup in the dispatch cycle
    push(6'd35, 32'd3, 32'd11, 32'h300);
    rs_if.wakeup_active = 1'b1;
    rs_if.wakeup_tag = 6'd41;
    rs_if.wakeup_value = 32'd3;
    disp(6'd35, 6'd41, 1'b0, 32'd0,
         6'd4, 1'b1, 32'd11, 32'h300);
    rs_if.wakeup_active = 1'b0;
    chk("dw_ivalid", 64'(rs_if.issue_valid), 64'd1);
    chk("dw_v1", 64'(rs_if.issue_rs1_value), 64'd3);
    step();
    chk("dw_occ", 64'(occupancy), 64'd0);

    // fill to capacity
    rs_if.issue_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push(6'(i), 32'(i), 32'(i + 100),
           32'(i + 1000));
      disp(6'(i), 6'd0, 1'b1, 32'(i),
           6'd0, 1'b1, 32'(i + 100),
           32'(i + 1000));
    end
    chk("full_occ", 64'(occupancy), 64'd8);
    chk("full_drdy", 64'(rs_if.dispatch_ready), 64'd0);
    disp(6'd60, 6'd0, 1'b1, 32'd60,
         6'd0, 1'b1, 32'd61, 32'h600);
    chk("full_9th", 64'(occupancy), 64'd8);
    rs_if.issue_ready = 1'b1;
    step();
    rs_if.issue_ready = 1'b0;
    chk("full_occ7", 64'(occupancy), 64'd7);
    chk("full_drdy1", 64'(rs_if.dispatch_ready),
        64'd1);
    rs_if.issue_ready = 1'b1;
    repeat (7) step();
    chk("full_drain", 64'(occupancy), 64'd0);

    // ordering under backpressure
    rs_if.issue_ready = 1'b0;
    push(6'd10, 32'd1, 32'd2, 32'h10);
    push(6'd12, 32'd3, 32'd4, 32'h12);
    disp(6'd10, 6'd0, 1'b1, 32'd1,
         6'd0, 1'b1, 32'd2, 32'h10);
    disp(6'd11, 6'd50, 1'b0, 32'd0,
         6'd0, 1'b1, 32'd6, 32'h11);
    disp(6'd12, 6'd0, 1'b1, 32'd3,
         6'd0, 1'b1, 32'd4, 32'h12);
    chk("ord_sel0", 64'(rs_if.issue_rd), 64'd10);
    step();
    step();
    chk("ord_hold", 64'(rs_if.issue_rd), 64'd10);
    chk("ord_hold_v", 64'(rs_if.issue_rs2_value),
        64'd2);
    rs_if.issue_ready = 1'b1;
    step();
    chk("ord_sel2", 64'(rs_if.issue_rd), 64'd12);
    step();
    chk("ord_empty", 64'(rs_if.issue_valid), 64'd0);
    chk("ord_occ", 64'(occupancy), 64'd1);
    push(6'd11, 32'h55, 32'd6, 32'h11);
    rs_if.wakeup_active = 1'b1;
    rs_if.wakeup_tag = 6'd50;
    rs_if.wakeup_value = 32'h55;
    step();
    rs_if.wakeup_active = 1'b0;
    chk("ord_b_rd", 64'(rs_if.issue_rd), 64'd11);
    step();
    chk("ord_occ0", 64'(occupancy), 64'd0);

    // flush and mid-stream reset
    rs_if.issue_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      disp(6'(20 + i), 6'd0, 1'b1, 32'(i),
           6'd0, 1'b1, 32'(i), 32'(i));
    chk("fl_occ5", 64'(occupancy), 64'd5);
    flush = 1'b1;
    disp(6'd30, 6'd0, 1'b1, 32'd1,
         6'd0, 1'b1, 32'd1, 32'd1);
    flush = 1'b0;
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_ivalid", 64'(rs_if.issue_valid), 64'd0);
    for (int i = 0; i < 3; i++)
      disp(6'(40 + i), 6'd0, 1'b1, 32'(i),
           6'd0, 1'b1, 32'(i), 32'(i));
    chk("rs_occ3", 64'(occupancy), 64'd3);
    chk("rs_pre_iv", 64'(rs_if.issue_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rs_occ", 64'(occupancy), 64'd0);
    chk("rs_ivalid", 64'(rs_if.issue_valid), 64'd0);
    chk("rs_ird", 64'(rs_if.issue_rd), 64'd0);
    chk("rs_drdy", 64'(rs_if.dispatch_ready), 64'd1);
    step();
    reset_n = 1'b1;
    rs_if.issue_ready = 1'b1;
    push(6'd50, 32'd8, 32'd9, 32'h500);
    disp(6'd50, 6'd0, 1'b1, 32'd8,
         6'd0, 1'b1, 32'd9, 32'h500);
    chk("post_rst_iv", 64'(rs_if.issue_valid), 64'd1);
    step();
    chk("post_rst_occ", 64'(occupancy), 64'd0);
    rs_if.issue_ready = 1'b0;
    step();
    chk("sb_left", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_err);
    $finish;
  end
endmodule
